// File: rtl/ram_lsu.sv
// ram_lsu: word-organised little-endian data RAM with valid/ready requests, wait states, registered response and misalignment detection.
// Ports: clk, rst (sync, active-high); req_valid/req_ready request handshake; we, mem_ctrl (0 byte, 1 half, 2 word, 3 reserved),
// ld_unsigned, address, data_in request fields; resp_valid pulse with data_out and misaligned; busy = ~req_ready.
// Build option: define RAM_MISALIGN_TRAP_EN to fault misaligned/reserved accesses; otherwise they are aligned down and complete.
module ram_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [1:0]  mem_ctrl,
  input  logic        ld_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        resp_valid,
  output logic [31:0] data_out,
  output logic        misaligned,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic l_we, l_uns;
  logic [1:0] l_ctrl;
  logic [AW+1:0] l_addr;
  logic [31:0] l_data;
  logic [31:0] mem [DEPTH_WORDS];
  logic idle, accept, go_resp, c_we, c_uns, fault, res_mis;
  logic [1:0] c_ctrl, ctrl, lane;
  logic [AW+1:0] c_addr;
  logic [AW-1:0] idx;
  logic [31:0] c_data, word, ld_val, wd, res_data;
  logic [15:0] sh;
  logic [3:0] be;
  logic unused_hi;
  assign unused_hi = &{1'b0, address[31:AW+2]};
  assign idle = state == IDLE;
  assign req_ready = idle;
  assign busy = ~idle;
  assign accept = idle & req_valid;
  // With zero wait states the commit edge is the acceptance edge, so the live inputs are used instead of the latched copy.
  assign go_resp = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == 4'(WAIT_STATES - 1));
  assign c_we = idle ? we : l_we;
  assign c_uns = idle ? ld_unsigned : l_uns;
  assign c_ctrl = idle ? mem_ctrl : l_ctrl;
  assign c_addr = idle ? address[AW+1:0] : l_addr;
  assign c_data = idle ? data_in : l_data;
  assign idx = c_addr[AW+1:2];
`ifdef RAM_MISALIGN_TRAP_EN
  assign ctrl = c_ctrl;
  assign fault = c_ctrl == 2'd3 || (c_ctrl == 2'd1 && c_addr[0]) || (c_ctrl == 2'd2 && c_addr[1:0] != 2'd0);
  assign lane = c_addr[1:0];
`else
  assign ctrl = c_ctrl == 2'd3 ? 2'd2 : c_ctrl;
  assign fault = 1'b0;
  assign lane = ctrl == 2'd0 ? c_addr[1:0] : ctrl == 2'd1 ? {c_addr[1], 1'b0} : 2'd0;
`endif
  assign word = mem[idx];
  assign sh = 16'(word >> {lane, 3'b000});
  assign ld_val = ctrl == 2'd0 ? {{24{~c_uns & sh[7]}}, sh[7:0]} :
                  ctrl == 2'd1 ? {{16{~c_uns & sh[15]}}, sh[15:0]} : word;
  assign be = ctrl == 2'd0 ? 4'b0001 << lane : ctrl == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd = ctrl == 2'd0 ? {4{c_data[7:0]}} : ctrl == 2'd1 ? {2{c_data[15:0]}} : c_data;
  always_ff @(posedge clk)
    if (!rst && go_resp && c_we && !fault)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      resp_valid <= 1'b0;
      data_out <= 32'd0;
      misaligned <= 1'b0;
      res_data <= 32'd0;
      res_mis <= 1'b0;
      l_we <= 1'b0;
      l_uns <= 1'b0;
      l_ctrl <= 2'd0;
      l_addr <= '0;
      l_data <= 32'd0;
    end else begin
      state <= go_resp ? RESP : accept ? WAIT : state == WAIT ? WAIT : IDLE;
      cnt <= state == WAIT ? cnt + 4'd1 : 4'd0;
      resp_valid <= state == RESP;
      if (state == RESP) begin
        data_out <= res_data;
        misaligned <= res_mis;
      end
      if (go_resp) begin
        res_data <= (c_we | fault) ? 32'd0 : ld_val;
        res_mis <= fault;
      end
      if (accept) begin
        l_we <= we;
        l_uns <= ld_unsigned;
        l_ctrl <= mem_ctrl;
        l_addr <= address[AW+1:0];
        l_data <= data_in;
      end
    end
  end
endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: table-driven check of ram_lsu loads/stores, latency, faults, wrap-around and reset abort.
module tb_ram_lsu;
  localparam int DEPTH = 1024;
  localparam int WS = 1;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, we, ld_unsigned, resp_valid, misaligned, busy;
  logic [1:0] mem_ctrl;
  logic [31:0] address, data_in, data_out;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic we;
    logic [1:0] ctrl;
    logic uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic exp_mis;
  } vec_t;
  vec_t v [18];
  ram_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .we(we),
    .mem_ctrl(mem_ctrl), .ld_unsigned(ld_unsigned), .address(address), .data_in(data_in),
    .resp_valid(resp_valid), .data_out(data_out), .misaligned(misaligned), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic xfer(input vec_t t, input string nm);
    int n;
    @(negedge clk);
    chk({nm, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    we = t.we;
    mem_ctrl = t.ctrl;
    ld_unsigned = t.uns;
    address = t.addr;
    data_in = t.data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    chk({nm, " latency"}, n, WS + 2);
    chk({nm, " data"}, data_out, t.exp_data);
    chk({nm, " mis"}, {31'd0, misaligned}, {31'd0, t.exp_mis});
  endtask
  initial begin
    int pulses;
    vec_t t;
    v[0]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, 32'h0, 1'b0};
    v[1]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0};
    v[2]  = '{1'b1, 2'd0, 1'b0, 32'h9, 32'hFFFF_FFAB, 32'h0, 1'b0};
    v[3]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h1234AB78, 1'b0};
    v[4]  = '{1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 32'hFFFFFFAB, 1'b0};
    v[5]  = '{1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 32'h000000AB, 1'b0};
    v[6]  = '{1'b1, 2'd2, 1'b0, 32'hC, 32'h11223344, 32'h0, 1'b0};
    v[7]  = '{1'b1, 2'd1, 1'b0, 32'hE, 32'hAAAA8001, 32'h0, 1'b0};
    v[8]  = '{1'b0, 2'd1, 1'b0, 32'hE, 32'h0, 32'hFFFF8001, 1'b0};
    v[9]  = '{1'b0, 2'd1, 1'b1, 32'hE, 32'h0, 32'h00008001, 1'b0};
    v[10] = '{1'b0, 2'd2, 1'b0, 32'hC, 32'h0, 32'h80013344, 1'b0};
`ifdef RAM_MISALIGN_TRAP_EN
    v[11] = '{1'b1, 2'd2, 1'b0, 32'h9, 32'hDEADBEEF, 32'h0, 1'b1};
    v[12] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h1234AB78, 1'b0};
`else
    v[11] = '{1'b1, 2'd2, 1'b0, 32'h9, 32'hDEADBEEF, 32'h0, 1'b0};
    v[12] = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0};
`endif
    v[13] = '{1'b1, 2'd2, 1'b0, DEPTH * 4, 32'hCAFEF00D, 32'h0, 1'b0};
    v[14] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    v[15] = '{1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h0000CAFE, 1'b0};
    v[16] = '{1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 32'hFFFFFFCA, 1'b0};
`ifdef RAM_MISALIGN_TRAP_EN
    v[17] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1};
`else
    v[17] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0};
`endif
    rst = 1'b1;
    req_valid = 1'b0;
    we = 1'b0;
    mem_ctrl = 2'd0;
    ld_unsigned = 1'b0;
    address = 32'd0;
    data_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst data_out", data_out, 32'd0);
    chk("rst mis", {31'd0, misaligned}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) xfer(v[i], $sformatf("vec%0d", i));
    // reset during WAIT abandons a store
    xfer('{1'b1, 2'd2, 1'b0, 32'h20, 32'h55555555, 32'h0, 1'b0}, "pre");
    @(negedge clk);
    req_valid = 1'b1;
    we = 1'b1;
    mem_ctrl = 2'd2;
    address = 32'h20;
    data_in = 32'h99999999;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort busy", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort ready", {31'd0, req_ready}, 32'd1);
    pulses = 0;
    repeat (5) begin
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    chk("abort no resp", pulses, 0);
    t = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h55555555, 1'b0};
    xfer(t, "abort load");
    // req_valid held high with changing fields during WAIT/RESP is not accepted
    @(negedge clk);
    req_valid = 1'b1;
    we = 1'b0;
    mem_ctrl = 2'd2;
    address = 32'h8;
    @(posedge clk);
    #1 we = 1'b1;
    address = 32'h0;
    data_in = 32'h0BADF00D;
    @(negedge clk);
    chk("hold wait ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("hold resp ready", {31'd0, req_ready}, 32'd0);
    chk("hold resp early", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hold data", data_out, v[12].exp_data);
    chk("hold ready back", {31'd0, req_ready}, 32'd1);
    t = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    xfer(t, "hold untouched");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
